// File: rtl/instr_mem_loader.sv
// Run-time loader for the 32x8 CPU instruction RAM: length header + payload over a byte stream.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module instr_mem_loader #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5,
   parameter logic [7:0]  FILL  = 8'h00
) (
   input  logic       clk_50m,
   input  logic       reset,
   input  logic       ld_start,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   input  logic [7:0] pc,
   output logic [7:0] instr,
   output logic       cpu_rst_n,
   output logic       busy,
   output logic       err,
   output logic [5:0] loaded_len
);

   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
   localparam logic [AW:0]   FullLen  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   One      = (AW+1)'(1);
   localparam logic [8:0]    DepthW   = 9'(DEPTH);

   typedef enum logic [2:0] {
      StClr,
      StIdle,
      StHdr,
      StLoad
`ifdef LOADER_CHECKSUM_EN
      , StCsum
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   loaded_len_q, loaded_len_d;
   logic          err_q, err_d;
   logic          cpu_rst_n_q;
   logic          release_d;

   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [AW:0]   addr_inc;
   logic          xfer;
   logic          hdr_bad;
   logic          last_byte;

   logic [7:0]    mem [DEPTH];

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       hold_q, hold_d;
`endif

   assign ld_ready   = (state_q == StHdr) || (state_q == StLoad)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == StCsum)
`endif
                       ;
   assign busy       = (state_q != StIdle);
   assign err        = err_q;
   assign cpu_rst_n  = cpu_rst_n_q;
   assign loaded_len = 6'(loaded_len_q);

   assign xfer      = ld_valid & ld_ready;
   assign addr_inc  = {1'b0, addr_q} + One;
   assign hdr_bad   = (ld_data == 8'h00) || ({1'b0, ld_data} > DepthW);
   assign last_byte = (addr_inc == len_q);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      loaded_len_d = loaded_len_q;
      err_d        = err_q;
      mem_we       = 1'b0;
      mem_wdata    = FILL;
`ifdef LOADER_CHECKSUM_EN
      csum_d       = csum_q;
      hold_d       = hold_q;
`endif
      unique case (state_q)
         StClr: begin
            mem_we = 1'b1;
            if (addr_q == LastAddr) begin
               state_d      = StIdle;
               addr_d       = '0;
               loaded_len_d = len_q;
            end else begin
               addr_d = addr_inc[AW-1:0];
            end
         end
         StIdle: begin
            if (ld_start) begin
               state_d = StHdr;
               err_d   = 1'b0;
            end
         end
         StHdr: begin
            if (xfer) begin
               if (hdr_bad) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  len_d   = ld_data[AW:0];
                  addr_d  = '0;
                  state_d = StLoad;
`ifdef LOADER_CHECKSUM_EN
                  csum_d  = 8'h00;
`endif
               end
            end
         end
         StLoad: begin
            if (xfer) begin
               mem_we    = 1'b1;
               mem_wdata = ld_data;
               addr_d    = addr_inc[AW-1:0];
`ifdef LOADER_CHECKSUM_EN
               csum_d    = csum_q ^ ld_data;
               if (last_byte) state_d = StCsum;
`else
               if (last_byte) begin
                  if (len_q == FullLen) begin
                     state_d      = StIdle;
                     addr_d       = '0;
                     loaded_len_d = len_q;
                  end else begin
                     state_d = StClr;
                  end
               end
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         StCsum: begin
            if (xfer) begin
               if (ld_data == csum_q) begin
                  hold_d = 1'b0;
                  if (len_q == FullLen) begin
                     state_d      = StIdle;
                     addr_d       = '0;
                     loaded_len_d = len_q;
                  end else begin
                     state_d = StClr;
                  end
               end else begin
                  // Bad image stays in RAM; hold keeps the processor in reset.
                  err_d   = 1'b1;
                  hold_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
`endif
         default: state_d = StClr;
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   assign release_d = (state_d == StIdle) && !hold_d;
`else
   assign release_d = (state_d == StIdle);
`endif

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         state_q      <= StClr;
         addr_q       <= '0;
         len_q        <= '0;
         loaded_len_q <= '0;
         err_q        <= 1'b0;
         cpu_rst_n_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         loaded_len_q <= loaded_len_d;
         err_q        <= err_d;
         cpu_rst_n_q  <= release_d;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         csum_q <= 8'h00;
         hold_q <= 1'b0;
      end else begin
         csum_q <= csum_d;
         hold_q <= hold_d;
      end
   end
`endif

   always_ff @(posedge clk_50m) begin
      if (mem_we) mem[addr_q] <= mem_wdata;
   end

   assign instr = ({1'b0, pc} < DepthW) ? mem[pc[AW-1:0]] : FILL;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader: reset sweep, loads, bad headers, stalls,
// reset mid-load, and the checksum path when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;

   logic       clk_50m = 1'b0;
   logic       reset;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic [7:0] pc;
   logic [7:0] instr;
   logic       cpu_rst_n;
   logic       busy;
   logic       err;
   logic [5:0] loaded_len;

   int n_tests = 0;
   int n_fail  = 0;

   always #10 clk_50m = ~clk_50m;

   instr_mem_loader dut (
      .clk_50m    (clk_50m),
      .reset      (reset),
      .ld_start   (ld_start),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .pc         (pc),
      .instr      (instr),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .err        (err),
      .loaded_len (loaded_len)
   );

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      ld_valid = 1'b1;
      ld_data  = b;
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      n_tests++;
      if ({cpu_rst_n, busy, ld_ready, err, loaded_len} !== {1'b0, 1'b1, 1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got rst_n=%b busy=%b rdy=%b err=%b len=%0d, expected 0 1 0 0 0",
                  cpu_rst_n, busy, ld_ready, err, loaded_len);
      end
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         n_tests++;
         if (cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_sweep_hold cycle %0d: got rst_n=%b busy=%b, expected 0 1",
                     i, cpu_rst_n, busy);
         end
         tick();
      end
      n_tests++;
      if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_sweep_release: got rst_n=%b busy=%b, expected 1 0", cpu_rst_n, busy);
      end
      for (int i = 0; i < 32; i++) begin
         pc = 8'(i);
         #1;
         n_tests++;
         if (instr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_fill pc=%0d: got %h, expected 00", i, instr);
         end
      end
   endtask

   task automatic test_load_short();
      logic [7:0] img [32];
      int cnt;
      for (int i = 0; i < 32; i++) img[i] = 8'h00;
      img[0] = 8'h49; img[1] = 8'hC1; img[2] = 8'h18;
      start_load();
      n_tests++;
      if (cpu_rst_n !== 1'b0 || ld_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_hold: got rst_n=%b rdy=%b, expected 0 1", cpu_rst_n, ld_ready);
      end
      send(8'h03);
      cnt = 1;
      send(8'h49); send(8'hC1); send(8'h18);
      cnt += 3;
      while (cpu_rst_n !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      n_tests++;
      if (cnt !== 33) begin
         n_fail++;
         $display("FAIL load3_latency: got %0d cycles, expected 33", cnt);
      end
      n_tests++;
      if (loaded_len !== 6'd3 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL load3_status: got len=%0d err=%b, expected 3 0", loaded_len, err);
      end
      for (int i = 0; i < 32; i++) begin
         pc = 8'(i);
         #1;
         n_tests++;
         if (instr !== img[i]) begin
            n_fail++;
            $display("FAIL load3_mem pc=%0d: got %h, expected %h", i, instr, img[i]);
         end
      end
   endtask

   task automatic test_bad_header();
      logic [7:0] hdrs [2];
      logic [7:0] img [4];
      hdrs[0] = 8'h00; hdrs[1] = 8'h21;
      img[0] = 8'h49; img[1] = 8'hC1; img[2] = 8'h18; img[3] = 8'h00;
      for (int h = 0; h < 2; h++) begin
         start_load();
         n_tests++;
         if (err !== 1'b0 || cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_hdr_start %h: got err=%b rst_n=%b, expected 0 0",
                     hdrs[h], err, cpu_rst_n);
         end
         send(hdrs[h]);
         n_tests++;
         if ({err, cpu_rst_n, busy, loaded_len} !== {1'b1, 1'b1, 1'b0, 6'd3}) begin
            n_fail++;
            $display("FAIL bad_hdr %h: got err=%b rst_n=%b busy=%b len=%0d, expected 1 1 0 3",
                     hdrs[h], err, cpu_rst_n, busy, loaded_len);
         end
         for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            #1;
            n_tests++;
            if (instr !== img[i]) begin
               n_fail++;
               $display("FAIL bad_hdr_mem pc=%0d: got %h, expected %h", i, instr, img[i]);
            end
         end
      end
   endtask

   task automatic test_full();
      logic [7:0] b;
      int cnt;
      start_load();
      send(8'h20);
      cnt = 1;
      for (int i = 0; i < 32; i++) begin
         send(8'(i * 7 + 5));
         cnt++;
      end
      n_tests++;
      if (cpu_rst_n !== 1'b1 || busy !== 1'b0 || loaded_len !== 6'd32 || cnt !== 33) begin
         n_fail++;
         $display("FAIL full_done: got rst_n=%b busy=%b len=%0d, expected 1 0 32",
                  cpu_rst_n, busy, loaded_len);
      end
      for (int i = 0; i < 32; i++) begin
         b = 8'(i * 7 + 5);
         pc = 8'(i);
         #1;
         n_tests++;
         if (instr !== b) begin
            n_fail++;
            $display("FAIL full_mem pc=%0d: got %h, expected %h", i, instr, b);
         end
      end
   endtask

   task automatic test_toggle_valid();
      logic [7:0] b;
      int cnt;
      start_load();
      send(8'h0C);
      for (int i = 0; i < 12; i++) begin
         send(8'hA0 + 8'(i));
         ld_data = 8'hEE;
         if (i == 5) ld_start = 1'b1;
         tick();
         ld_start = 1'b0;
      end
      n_tests++;
      if (busy !== 1'b1 || ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_in_clr: got busy=%b rdy=%b, expected 1 0", busy, ld_ready);
      end
      cnt = 0;
      while (cpu_rst_n !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      n_tests++;
      if (cpu_rst_n !== 1'b1 || loaded_len !== 6'd12 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_done: got rst_n=%b len=%0d err=%b, expected 1 12 0",
                  cpu_rst_n, loaded_len, err);
      end
      for (int i = 0; i < 32; i++) begin
         b = (i < 12) ? 8'hA0 + 8'(i) : 8'h00;
         pc = 8'(i);
         #1;
         n_tests++;
         if (instr !== b) begin
            n_fail++;
            $display("FAIL toggle_mem pc=%0d: got %h, expected %h", i, instr, b);
         end
      end
      pc = 8'h40;
      #1;
      n_tests++;
      if (instr !== 8'h00) begin
         n_fail++;
         $display("FAIL pc_out_of_range: got %h, expected 00", instr);
      end
   endtask

   task automatic test_reset_mid_load();
      int cnt;
      start_load();
      send(8'h05);
      send(8'h11);
      send(8'h22);
      reset = 1'b0;
      #1;
      n_tests++;
      if ({cpu_rst_n, busy, ld_ready, loaded_len} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL mid_reset_async: got rst_n=%b busy=%b rdy=%b len=%0d, expected 0 1 0 0",
                  cpu_rst_n, busy, ld_ready, loaded_len);
      end
      tick();
      tick();
      reset = 1'b1;
      cnt = 0;
      while (cpu_rst_n !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      n_tests++;
      if (cnt !== 32 || loaded_len !== 6'd0) begin
         n_fail++;
         $display("FAIL mid_reset_sweep: got %0d cycles len=%0d, expected 32 0", cnt, loaded_len);
      end
      for (int i = 0; i < 32; i++) begin
         pc = 8'(i);
         #1;
         n_tests++;
         if (instr !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_mem pc=%0d: got %h, expected 00", i, instr);
         end
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int cnt;
      start_load();
      send(8'h02); send(8'hAA); send(8'h0F); send(8'hA5);
      cnt = 0;
      while (cpu_rst_n !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      n_tests++;
      if (cpu_rst_n !== 1'b1 || err !== 1'b0 || loaded_len !== 6'd2) begin
         n_fail++;
         $display("FAIL csum_good: got rst_n=%b err=%b len=%0d, expected 1 0 2",
                  cpu_rst_n, err, loaded_len);
      end
      pc = 8'd1;
      #1;
      n_tests++;
      if (instr !== 8'h0F) begin
         n_fail++;
         $display("FAIL csum_good_mem: got %h, expected 0F", instr);
      end
      start_load();
      send(8'h02); send(8'h11); send(8'h22); send(8'hA4);
      tick(); tick(); tick();
      n_tests++;
      if ({err, cpu_rst_n, busy, loaded_len} !== {1'b1, 1'b0, 1'b0, 6'd2}) begin
         n_fail++;
         $display("FAIL csum_bad: got err=%b rst_n=%b busy=%b len=%0d, expected 1 0 0 2",
                  err, cpu_rst_n, busy, loaded_len);
      end
      start_load();
      send(8'h01); send(8'h5A); send(8'h5A);
      cnt = 0;
      while (cpu_rst_n !== 1'b1 && cnt < 100) begin
         tick();
         cnt++;
      end
      n_tests++;
      if (cpu_rst_n !== 1'b1 || err !== 1'b0 || loaded_len !== 6'd1) begin
         n_fail++;
         $display("FAIL csum_recover: got rst_n=%b err=%b len=%0d, expected 1 0 1",
                  cpu_rst_n, err, loaded_len);
      end
   endtask
`endif

   initial begin
      reset    = 1'b0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_data  = 8'h00;
      pc       = 8'h00;
      test_reset();
      test_load_short();
      test_bad_header();
      test_full();
      test_toggle_valid();
      test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
